// File: rtl/pri_arb_8.sv
// Registered N-way arbiter: fixed (highest index wins) or round-robin priority,
// grant held while the winner keeps requesting, capped at MAX_HOLD cycles, gated by en.
module pri_arb_8 #(
  parameter int unsigned N        = 8,
  parameter int unsigned IDW      = 3,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           rr_mode,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  localparam int unsigned HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HCW'(MAX_HOLD - 1);
  localparam logic [HCW-1:0] HOLD_SAT  = HCW'(MAX_HOLD);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic [IDW-1:0] last_q, last_d;

  logic [IDW-1:0] start;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] win_id;
  logic           win_found;
  logic           cap_hit;
  logic           drop;

  // Fixed mode is a downward scan from N-1; round-robin starts one below the last
  // winner. Index arithmetic wraps naturally because N is a power of two.
  always_comb begin
    start     = rr_mode ? (last_q - IDW'(1)) : IDW'(N - 1);
    cand      = '0;
    win_id    = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = start - IDW'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign cap_hit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  assign drop    = !req[id_q] || !en || cap_hit;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    hold_d  = hold_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (en && win_found) begin
          state_d        = ST_GRANT;
          gnt_d          = '0;
          gnt_d[win_id]  = 1'b1;
          id_d           = win_id;
          hold_d         = '0;
          last_d         = win_id;
        end
      end
      ST_GRANT: begin
        if (drop) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          id_d    = '0;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        id_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      hold_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_pri_arb_8.sv
// Bench for pri_arb_8: a capped-hold instance (MAX_HOLD=4) and an unlimited one
// (MAX_HOLD=0) share stimulus; each is tracked by its own reference model.
module tb_pri_arb_8;

  localparam int NUM = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rr_mode;
  logic [7:0] req;

  logic [7:0] gnt0, gnt1;
  logic [2:0] id0, id1;
  logic       v0, v1;

  int compared   = 0;
  int mismatched = 0;
  int run;

  int mbusy [2] = '{0, 0};
  int mid   [2] = '{0, 0};
  int mheld [2] = '{0, 0};
  int mlast [2] = '{0, 0};
  int mh    [2] = '{4, 0};

  logic [7:0] seq_exp [15] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00,
                               8'h01, 8'h01, 8'h01, 8'h01, 8'h00,
                               8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
  logic [7:0] fix_exp [15] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00,
                               8'h80, 8'h80, 8'h80, 8'h80, 8'h00,
                               8'h80, 8'h80, 8'h80, 8'h80, 8'h00};

  pri_arb_8 #(.N(8), .IDW(3), .MAX_HOLD(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rr_mode(rr_mode), .req(req),
    .gnt(gnt0), .gnt_id(id0), .gnt_valid(v0)
  );

  pri_arb_8 #(.N(8), .IDW(3), .MAX_HOLD(0)) u_dut_nh (
    .clk(clk), .rst_n(rst_n), .en(en), .rr_mode(rr_mode), .req(req),
    .gnt(gnt1), .gnt_id(id1), .gnt_valid(v1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input logic rr, input int last);
    int start;
    start = rr ? (last + NUM - 1) % NUM : NUM - 1;
    for (int k = 0; k < NUM; k++) begin
      int idx;
      idx = (start - k + NUM) % NUM;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  // Reference model: mheld counts visible grant cycles so far in the current win.
  always @(posedge clk or negedge rst_n) begin
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        mbusy[m] <= 0; mid[m] <= 0; mheld[m] <= 0; mlast[m] <= 0;
      end else if (mbusy[m] == 0) begin
        if (en && req != 8'h00) begin
          mbusy[m] <= 1;
          mid[m]   <= pick(req, rr_mode, mlast[m]);
          mlast[m] <= pick(req, rr_mode, mlast[m]);
          mheld[m] <= 1;
        end
      end else if (!req[mid[m]] || !en || (mh[m] != 0 && mheld[m] == mh[m])) begin
        mbusy[m] <= 0; mid[m] <= 0; mheld[m] <= 0;
      end else begin
        mheld[m] <= mheld[m] + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m0_gnt",   gnt0, (mbusy[0] != 0) ? (8'h01 << mid[0]) : 8'h00);
    chk("m0_id",    id0,  (mbusy[0] != 0) ? mid[0] : 0);
    chk("m0_valid", v0,   mbusy[0]);
    chk("m1_gnt",   gnt1, (mbusy[1] != 0) ? (8'h01 << mid[1]) : 8'h00);
    chk("m1_id",    id1,  (mbusy[1] != 0) ? mid[1] : 0);
    chk("m1_valid", v1,   mbusy[1]);
    chk("inv_onehot0", $onehot0(gnt0), 1);
    chk("inv_onehot1", $onehot0(gnt1), 1);
    chk("inv_shift0", gnt0, {7'b0, v0} << id0);
    chk("inv_shift1", gnt1, {7'b0, v1} << id1);
  end

  task automatic do_reset();
    req = 8'h00; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; rr_mode = 1'b0; req = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_gnt", gnt0, 8'h00);
    chk("reset_id", id0, 3'd0);
    rst_n = 1'b1;

    // fixed priority, release on req drop, dead cycle, next winner
    @(negedge clk); en = 1'b1; req = 8'h26;
    @(negedge clk); chk("fix_gnt", gnt0, 8'h20); chk("fix_id", id0, 3'd5);
    req = 8'h06;
    @(negedge clk); chk("fix_release", gnt0, 8'h00);
    @(negedge clk); chk("fix_next_gnt", gnt0, 8'h04); chk("fix_next_id", id0, 3'd2);
    req = 8'h00;
    repeat (2) @(negedge clk);

    // asynchronous reset during a grant
    req = 8'h80;
    @(negedge clk); chk("areset_pre", gnt0, 8'h80);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_gnt", gnt0, 8'h00);
    chk("areset_id", id0, 3'd0);
    chk("areset_valid", v0, 1'b0);
    @(negedge clk); rst_n = 1'b1; req = 8'h00;

    // round-robin with cap alternates 7 and 0
    rr_mode = 1'b1; req = 8'h81;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); chk("rr_seq", gnt0, seq_exp[c]);
    end

    // fixed with cap never serves index 0
    do_reset();
    rr_mode = 1'b0; req = 8'h81;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); chk("fix_cap_seq", gnt0, fix_exp[c]);
    end

    // en gating, last preserved across en=0
    do_reset();
    rr_mode = 1'b1; en = 1'b1; req = 8'h08;
    @(negedge clk); chk("en_id3", id0, 3'd3);
    en = 1'b0;
    @(negedge clk); chk("en_off", gnt0, 8'h00);
    req = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk("en_blocked", gnt0, 8'h00);
    end
    en = 1'b1;
    @(negedge clk); chk("en_rr_gnt", gnt0, 8'h04); chk("en_rr_id", id0, 3'd2);

    // unlimited hold on the MAX_HOLD=0 instance
    do_reset();
    rr_mode = 1'b0; en = 1'b1; req = 8'h10;
    run = 0;
    repeat (100) begin
      @(negedge clk);
      if (gnt1 == 8'h10) run++;
    end
    chk("nohold_100", run, 100);

    // random stress, model and invariants checked every cycle
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) req = 8'($urandom);
      en      = ($urandom_range(0, 7) != 0);
      rr_mode = 1'($urandom_range(0, 1));
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
